// File: rtl/segment_sampler_if.sv
`default_nettype none
// segment_sampler_if: request/result bundle between segment selection and the sampler.
interface segment_sampler_if;
    logic              in_valid;
    logic [1:0]        in_segment_type;
    logic signed [7:0] in_segment_from;
    logic signed [7:0] in_segment_to;
    logic              out_ready;
    logic              out_valid;
    logic signed [7:0] out_value;
    logic              out_error;

    modport master (
        output in_valid, in_segment_type, in_segment_from, in_segment_to,
        input  out_ready, out_valid, out_value, out_error
    );

    modport slave (
        input  in_valid, in_segment_type, in_segment_from, in_segment_to,
        output out_ready, out_valid, out_value, out_error
    );
endinterface
`default_nettype wire

// File: rtl/segment_sampler.sv
`default_nettype none
// segment_sampler: draws one value inside a chosen segment using an 8-bit LFSR
// (uniform by rejection, exponential by bit-serial geometric draw).
module segment_sampler #(
    parameter logic [1:0] UNIFORM    = 2'd3,
    parameter logic [1:0] EXPDOWN    = 2'd1,
    parameter logic [1:0] EXPUP      = 2'd2,
    parameter int         MAX_REJECT = 16
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_load_seed,
    input  logic [7:0] in_seed,
    segment_sampler_if.slave seg
);

    localparam int AW = $clog2(MAX_REJECT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UNI  = 2'd1,
        GEO  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [7:0]        lfsr;
    logic [1:0]        seg_type;
    logic signed [8:0] from_x;
    logic signed [8:0] to_x;
    logic signed [8:0] span;
    logic [8:0]        k;
    logic [AW-1:0]     attempt;

    logic [7:0]        lfsr_next;
    logic [7:0]        mask;
    logic [7:0]        cand;
    logic              cand_ok;
    logic              geo_up;
    logic signed [8:0] req_from;
    logic signed [8:0] req_to;
    logic signed [8:0] req_span;
    logic signed [8:0] uni_res;
    logic signed [8:0] geo_res;

    function automatic logic [7:0] mask_for(input logic [7:0] s);
        logic [7:0] m;
        m = 8'd1;
        for (int i = 1; i < 8; i++) begin
            if (m < s) m = {m[6:0], 1'b1};
        end
        return m;
    endfunction

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign req_from  = {seg.in_segment_from[7], seg.in_segment_from};
    assign req_to    = {seg.in_segment_to[7], seg.in_segment_to};
    assign req_span  = req_to - req_from;

    // In UNI the span is known positive, so its low 8 bits carry the magnitude.
    assign mask    = mask_for(span[7:0]);
    assign cand    = lfsr & mask;
    assign cand_ok = ({1'b0, cand} <= $unsigned(span));
    assign uni_res = from_x + $signed({1'b0, cand});
    assign geo_up  = (seg_type == EXPUP) || (seg_type != EXPDOWN);
    assign geo_res = geo_up ? (to_x - $signed(k)) : (from_x + $signed(k));

    assign seg.out_ready = (state == IDLE);

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state         <= IDLE;
            lfsr          <= 8'h01;
            seg_type      <= 2'd0;
            from_x        <= 9'sd0;
            to_x          <= 9'sd0;
            span          <= 9'sd0;
            k             <= 9'd0;
            attempt       <= '0;
            seg.out_valid <= 1'b0;
            seg.out_value <= 8'sd0;
            seg.out_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_load_seed) lfsr <= (in_seed == 8'h00) ? 8'h01 : in_seed;
                    if (seg.in_valid) begin
                        seg_type <= seg.in_segment_type;
                        from_x   <= req_from;
                        to_x     <= req_to;
                        span     <= req_span;
                        k        <= 9'd0;
                        attempt  <= '0;
                        if (req_span < 0 || seg.in_segment_type == 2'd0) begin
                            seg.out_value <= seg.in_segment_from;
                            seg.out_error <= 1'b1;
                            seg.out_valid <= 1'b1;
                            state         <= DONE;
                        end else if (req_span == 0) begin
                            seg.out_value <= seg.in_segment_from;
                            seg.out_error <= 1'b0;
                            seg.out_valid <= 1'b1;
                            state         <= DONE;
                        end else if (seg.in_segment_type == UNIFORM) begin
                            state <= UNI;
                        end else begin
                            state <= GEO;
                        end
                    end
                end
                UNI: begin
                    lfsr <= lfsr_next;
                    if (cand_ok) begin
                        seg.out_value <= uni_res[7:0];
                        seg.out_error <= 1'b0;
                        seg.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (attempt == AW'(MAX_REJECT - 1)) begin
                        // Out of attempts: fall back to the lower bound without flagging.
                        seg.out_value <= from_x[7:0];
                        seg.out_error <= 1'b0;
                        seg.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        attempt <= attempt + 1'b1;
                    end
                end
                GEO: begin
                    lfsr <= lfsr_next;
                    if (!lfsr[0] || k == $unsigned(span)) begin
                        seg.out_value <= geo_res[7:0];
                        seg.out_error <= 1'b0;
                        seg.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        k <= k + 9'd1;
                    end
                end
                DONE: begin
                    seg.out_valid <= 1'b0;
                    seg.out_error <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
